timer_periph_bank: RTL and testbench

Memory-mapped peripheral block on the CPU data bus: a parametrised bank of reload timers plus LED and 7-segment digit output registers. It generalises the single-timer peripheral with N channels, configurable widths, one-shot mode, write-1-to-clear interrupt flags and a per-channel interrupt vector. It sits beside data memory in the address decoder and drives the CPU's external interrupt request.

---
 rtl/timer_periph_bank_pkg.sv | 32 +++
 rtl/timer_periph_bank_if.sv | 13 +
 rtl/timer_periph_bank_channel.sv | 122 ++++++++++++
 rtl/timer_periph_bank.sv | 130 +++++++++++++
 tb/tb_timer_periph_bank.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/timer_periph_bank_pkg.sv
// Shared definitions for the timer peripheral bank: register offsets,
// channel register selector, TCON bit positions and channel stride.
package periph_pkg;

  // Each channel occupies a 16-byte window starting at the block base
  localparam int unsigned CH_STRIDE = 16;

  // Register offsets inside a channel window
  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_PS   = 4'hC;

  // Block-level register offsets from the base address
  localparam logic [31:0] OFF_LED  = 32'h0000_0100;
  localparam logic [31:0] OFF_DIGI = 32'h0000_0104;
  localparam logic [31:0] OFF_IRQ  = 32'h0000_0108;

  // TCON bit positions
  localparam int TCON_EN   = 0;
  localparam int TCON_IE   = 1;
  localparam int TCON_PEND = 2;
  localparam int TCON_OS   = 3;

  typedef enum logic [1:0] {
    REG_TH   = 2'd0,
    REG_TL   = 2'd1,
    REG_TCON = 2'd2,
    REG_PS   = 2'd3
  } chreg_e;

endpackage

// File: rtl/timer_periph_bank_if.sv
// CPU data-bus port of the timer peripheral bank. The CPU side uses the
// master modport, the peripheral uses the slave modport. rdata is
// combinational in the peripheral.
interface timer_periph_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_periph_bank_channel.sv
// One reload timer channel: TH (reload), TL (count), TCON (EN/IE/PEND/
// ONESHOT) and, when TIMER_PRESCALE_EN is defined, a PS register with its
// prescale counter. Without TIMER_PRESCALE_EN the channel ticks every cycle.
module timer_channel
  import periph_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_th_i,
  input  logic             wr_tl_i,
  input  logic             wr_tcon_i,
  input  logic             wr_ps_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] th_o,
  output logic [CNT_W-1:0] tl_o,
  output logic [CNT_W-1:0] ps_o,
  output logic [3:0]       tcon_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] th_q, th_d, tl_q, tl_d;
  logic             en_q, en_d, ie_q, ie_d, os_q, os_d, pend_q, pend_d;
  logic             tick, ovf;
  logic [CNT_W-1:0] wval;
  logic             unused_wdata;

  // Writes truncate to the counter width; the remaining bits are don't-care
  assign wval         = wdata_i[CNT_W-1:0];
  assign unused_wdata = ^wdata_i;

`ifdef TIMER_PRESCALE_EN
  logic [CNT_W-1:0] ps_q, ps_d, pcnt_q, pcnt_d;

  // Tick on the cycle the prescale counter reaches PS
  assign tick = (pcnt_q == ps_q);
  assign ps_o = ps_q;

  // Prescale counter runs 0..PS; restarts on TL/PS writes and while disabled
  always_comb begin
    ps_d   = wr_ps_i ? wval : ps_q;
    pcnt_d = pcnt_q + 1'b1;
    if (wr_tl_i || wr_ps_i || !en_q || tick) pcnt_d = '0;
  end

  // Prescale state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q   <= '0;
      pcnt_q <= '0;
    end else begin
      ps_q   <= ps_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  logic unused_ps;

  assign tick      = 1'b1;
  assign ps_o      = '0;
  assign unused_ps = wr_ps_i;
`endif

  assign ovf = en_q && tick && (tl_q == CNT_MAX);

  // Count/reload and TCON next state; priorities: TL write over count,
  // EN write over one-shot stop, overflow set over W1C clear
  always_comb begin
    th_d   = wr_th_i ? wval : th_q;
    tl_d   = tl_q;
    en_d   = en_q;
    ie_d   = ie_q;
    os_d   = os_q;
    pend_d = pend_q;
    if (en_q && tick) tl_d = ovf ? th_q : tl_q + 1'b1;
    if (wr_tl_i) tl_d = wval;
    if (ovf && os_q) en_d = 1'b0;
    if (wr_tcon_i) begin
      en_d = wdata_i[TCON_EN];
      ie_d = wdata_i[TCON_IE];
      os_d = wdata_i[TCON_OS];
      if (wdata_i[TCON_PEND]) pend_d = 1'b0;
    end
    if (ovf && ie_q) pend_d = 1'b1;
  end

  // Channel register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      os_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      os_q   <= os_d;
      pend_q <= pend_d;
    end
  end

  // Pack TCON for readback; unused bits read 0
  always_comb begin
    tcon_o            = '0;
    tcon_o[TCON_EN]   = en_q;
    tcon_o[TCON_IE]   = ie_q;
    tcon_o[TCON_PEND] = pend_q;
    tcon_o[TCON_OS]   = os_q;
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/timer_periph_bank.sv
// Timer peripheral bank top: address decode, read mux, LED and DIGI output
// registers and interrupt summary for N_CH timer_channel instances.
// Optional prescaler per channel is enabled by defining TIMER_PRESCALE_EN.
module timer_periph_bank
  import periph_pkg::*;
#(
  parameter int          N_CH   = 2,
  parameter int          CNT_W  = 32,
  parameter int          LED_W  = 8,
  parameter int          DIGI_W = 12,
  parameter logic [31:0] BASE   = 32'h4000_0000
) (
  input  logic               clk,
  input  logic               reset,
  timer_periph_bank_if.slave bus,
  output logic [LED_W-1:0]   led_o,
  output logic [DIGI_W-1:0]  digi_o,
  output logic [N_CH-1:0]    irq_vec_o,
  output logic               irqout_o
);

  localparam logic [31:0] CH_SPAN = 32'(N_CH * CH_STRIDE);

  logic [31:0]       off;
  logic              ch_hit, led_hit, digi_hit, irq_hit;
  logic [3:0]        ch_idx;
  chreg_e            reg_sel;
  logic [31:0]       rd_val;

  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;

  logic [CNT_W-1:0]  th_w   [N_CH];
  logic [CNT_W-1:0]  tl_w   [N_CH];
  logic [CNT_W-1:0]  ps_w   [N_CH];
  logic [3:0]        tcon_w [N_CH];
  logic [N_CH-1:0]   pend_w;

  // Channel windows are contiguous from BASE; only aligned words decode
  assign off      = bus.addr - BASE;
  assign ch_hit   = (off[1:0] == 2'b00) && (off < CH_SPAN);
  assign ch_idx   = off[7:4];
  assign led_hit  = (off == OFF_LED);
  assign digi_hit = (off == OFF_DIGI);
  assign irq_hit  = (off == OFF_IRQ);

  // Register select within the channel window
  always_comb begin
    reg_sel = REG_TH;
    case (off[3:0])
      OFF_TH:   reg_sel = REG_TH;
      OFF_TL:   reg_sel = REG_TL;
      OFF_TCON: reg_sel = REG_TCON;
      OFF_PS:   reg_sel = REG_PS;
      default:  reg_sel = REG_TH;
    endcase
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic sel;
    assign sel = bus.wr && ch_hit && (ch_idx == 4'(g));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_th_i   (sel && (reg_sel == REG_TH)),
      .wr_tl_i   (sel && (reg_sel == REG_TL)),
      .wr_tcon_i (sel && (reg_sel == REG_TCON)),
      .wr_ps_i   (sel && (reg_sel == REG_PS)),
      .wdata_i   (bus.wdata),
      .th_o      (th_w[g]),
      .tl_o      (tl_w[g]),
      .ps_o      (ps_w[g]),
      .tcon_o    (tcon_w[g]),
      .pend_o    (pend_w[g])
    );
  end

  // LED/DIGI next state from bus writes
  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (bus.wr && led_hit)  led_d  = bus.wdata[LED_W-1:0];
    if (bus.wr && digi_hit) digi_d = bus.wdata[DIGI_W-1:0];
  end

  // LED/DIGI output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  // Read mux: zero-extended register value, 0 when idle or unmapped
  always_comb begin
    rd_val = '0;
    if (bus.rd) begin
      if (ch_hit) begin
        for (int i = 0; i < N_CH; i++) begin
          if (ch_idx == 4'(i)) begin
            case (reg_sel)
              REG_TH:   rd_val[CNT_W-1:0] = th_w[i];
              REG_TL:   rd_val[CNT_W-1:0] = tl_w[i];
              REG_TCON: rd_val[3:0]       = tcon_w[i];
              REG_PS:   rd_val[CNT_W-1:0] = ps_w[i];
              default:  rd_val            = '0;
            endcase
          end
        end
      end else if (led_hit) begin
        rd_val[LED_W-1:0] = led_q;
      end else if (digi_hit) begin
        rd_val[DIGI_W-1:0] = digi_q;
      end else if (irq_hit) begin
        rd_val[N_CH-1:0] = pend_w;
      end
    end
  end

  assign bus.rdata = rd_val;
  assign led_o     = led_q;
  assign digi_o    = digi_q;
  assign irq_vec_o = pend_w;
  assign irqout_o  = |pend_w;

endmodule

// File: tb/tb_timer_periph_bank.sv
// Directed bench for timer_periph_bank (default parameters). Expected values
// are queued when a step is driven and compared when the DUT output is sampled.
module tb_timer_periph_bank;

  localparam logic [31:0] CH0  = 32'h4000_0000;
  localparam logic [31:0] CH1  = 32'h4000_0010;
  localparam logic [31:0] R_TH = 32'h0;
  localparam logic [31:0] R_TL = 32'h4;
  localparam logic [31:0] R_TC = 32'h8;
  localparam logic [31:0] R_PS = 32'hC;
  localparam logic [31:0] A_LED  = 32'h4000_0100;
  localparam logic [31:0] A_DIGI = 32'h4000_0104;
  localparam logic [31:0] A_IRQ  = 32'h4000_0108;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [1:0]  irq_vec;
  logic        irqout;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  timer_periph_bank_if bus();

  timer_periph_bank dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led_o     (led),
    .digi_o    (digi),
    .irq_vec_o (irq_vec),
    .irqout_o  (irqout)
  );

  always #5 clk = ~clk;

  task automatic expect_push(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_pop(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.wr = 1'b0;
  endtask

  // Samples rdata before the next edge, then lets that edge pass
  task automatic bus_read(input string tag, input logic [31:0] a, input logic r,
                          input logic [31:0] e);
    bus.rd = r; bus.addr = a;
    expect_push(tag, e);
    #2;
    compare_pop(bus.rdata);
    @(posedge clk); #1;
    bus.rd = 1'b0;
  endtask

  task automatic sig_check(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_push(tag, e);
    compare_pop(obs);
  endtask

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    tick_n(2);
    reset = 1'b1;

    // Load everything nonzero with ch0 overflowing, then reset mid-count
    bus_write(CH0 + R_TH, 32'h5);
    bus_write(CH0 + R_TL, 32'hFFFF_FFFF);
    bus_write(CH0 + R_TC, 32'h3);
    bus_write(CH1 + R_TH, 32'h11);
    bus_write(CH1 + R_TL, 32'h22);
    bus_write(CH1 + R_TC, 32'h2);
    bus_write(CH0 + R_PS, 32'h3);
    bus_write(CH1 + R_PS, 32'h4);
    bus_write(A_LED, 32'h3C);
    bus_write(A_DIGI, 32'h123);
    sig_check("pre_rst_irqout", 32'(irqout), 32'h1);
    sig_check("pre_rst_led", 32'(led), 32'h3C);
    reset = 1'b0;
    tick_n(1);
    reset = 1'b1;
    bus_read("rst_ch0_th", CH0 + R_TH, 1'b1, 32'h0);
    bus_read("rst_ch0_tl", CH0 + R_TL, 1'b1, 32'h0);
    bus_read("rst_ch0_tcon", CH0 + R_TC, 1'b1, 32'h0);
    bus_read("rst_ch0_ps", CH0 + R_PS, 1'b1, 32'h0);
    bus_read("rst_ch1_th", CH1 + R_TH, 1'b1, 32'h0);
    bus_read("rst_ch1_tl", CH1 + R_TL, 1'b1, 32'h0);
    bus_read("rst_ch1_tcon", CH1 + R_TC, 1'b1, 32'h0);
    bus_read("rst_led_reg", A_LED, 1'b1, 32'h0);
    bus_read("rst_digi_reg", A_DIGI, 1'b1, 32'h0);
    bus_read("rst_irq_reg", A_IRQ, 1'b1, 32'h0);
    sig_check("rst_led", 32'(led), 32'h0);
    sig_check("rst_digi", 32'(digi), 32'h0);
    sig_check("rst_irqout", 32'(irqout), 32'h0);

    // Ch1 overflow two edges after enable, reload from TH
    bus_write(CH1 + R_TH, 32'hFFFF_FFF0);
    bus_write(CH1 + R_TL, 32'hFFFF_FFFE);
    bus_write(CH1 + R_TC, 32'h3);
    bus_read("ch1_tl_e0", CH1 + R_TL, 1'b1, 32'hFFFF_FFFE);
    bus_read("ch1_tcon_e1", CH1 + R_TC, 1'b1, 32'h3);
    sig_check("ch1_irq_vec", 32'(irq_vec), 32'h2);
    sig_check("ch1_irqout", 32'(irqout), 32'h1);
    bus_read("ch1_tl_reload", CH1 + R_TL, 1'b1, 32'hFFFF_FFF0);
    bus_read("ch1_tcon_pend", CH1 + R_TC, 1'b1, 32'h7);
    bus_read("irq_summary", A_IRQ, 1'b1, 32'h2);
    bus_read("ch0_tl_idle", CH0 + R_TL, 1'b1, 32'h0);
    bus_read("ch0_tcon_idle", CH0 + R_TC, 1'b1, 32'h0);
    bus_write(CH1 + R_TC, 32'h4);
    sig_check("ch1_w1c_irq_vec", 32'(irq_vec), 32'h0);

    // Ch0 one-shot
    bus_write(CH0 + R_TH, 32'hFFFF_FFFD);
    bus_write(CH0 + R_TL, 32'hFFFF_FFFD);
    bus_write(CH0 + R_TC, 32'hB);
    tick_n(2);
    sig_check("os_no_early_irq", 32'(irqout), 32'h0);
    tick_n(1);
    bus_read("os_tcon", CH0 + R_TC, 1'b1, 32'hE);
    sig_check("os_irqout", 32'(irqout), 32'h1);
    bus_read("os_tl_hold", CH0 + R_TL, 1'b1, 32'hFFFF_FFFD);
    bus_write(CH0 + R_TC, 32'h4);
    sig_check("os_w1c_irqout", 32'(irqout), 32'h0);
    bus_read("os_tcon_clr", CH0 + R_TC, 1'b1, 32'h0);

    // TH = max makes ch0 overflow every enabled cycle
    bus_write(CH0 + R_TH, 32'hFFFF_FFFF);
    bus_write(CH0 + R_TL, 32'hFFFF_FFFF);
    bus_write(CH0 + R_TC, 32'h3);
    tick_n(1);
    bus_write(CH0 + R_TC, 32'h7);
    bus_read("w1c_vs_ovf", CH0 + R_TC, 1'b1, 32'h7);
    bus_write(CH0 + R_TL, 32'h1234);
    bus_read("tl_wr_vs_ovf", CH0 + R_TL, 1'b1, 32'h1234);
    bus_write(CH0 + R_TC, 32'h4);
    sig_check("ovf_stop_irqout", 32'(irqout), 32'h0);
    bus_write(CH0 + R_TL, 32'hFFFF_FFFF);
    bus_write(CH0 + R_TC, 32'h9);
    bus_write(CH0 + R_TC, 32'h9);
    bus_read("en_wr_vs_os", CH0 + R_TC, 1'b1, 32'h9);
    bus_read("os_stop", CH0 + R_TC, 1'b1, 32'h8);

    // Prescale on ch1
    bus_write(CH1 + R_PS, 32'h3);
`ifdef TIMER_PRESCALE_EN
    bus_read("ps_readback", CH1 + R_PS, 1'b1, 32'h3);
    bus_write(CH1 + R_TL, 32'h0);
    bus_write(CH1 + R_TC, 32'h1);
    tick_n(3);
    bus_read("ps_tl_0", CH1 + R_TL, 1'b1, 32'h0);
    bus_read("ps_tl_1", CH1 + R_TL, 1'b1, 32'h1);
    tick_n(2);
    bus_read("ps_tl_1b", CH1 + R_TL, 1'b1, 32'h1);
    bus_read("ps_tl_2", CH1 + R_TL, 1'b1, 32'h2);
`else
    bus_read("ps_readback", CH1 + R_PS, 1'b1, 32'h0);
    bus_write(CH1 + R_TL, 32'h0);
    bus_write(CH1 + R_TC, 32'h1);
    bus_read("nops_tl_0", CH1 + R_TL, 1'b1, 32'h0);
    bus_read("nops_tl_1", CH1 + R_TL, 1'b1, 32'h1);
    tick_n(2);
    bus_read("nops_tl_4", CH1 + R_TL, 1'b1, 32'h4);
`endif
    bus_write(CH1 + R_TC, 32'hFFFF_FFF8);
    bus_read("tcon_rsvd", CH1 + R_TC, 1'b1, 32'h8);
    bus_write(CH1 + R_TC, 32'h0);

    // LED/DIGI, unmapped and idle reads, read-during-write
    bus_write(A_LED, 32'hA5);
    bus_write(A_DIGI, 32'hFFF);
    bus_write(32'h4000_0200, 32'hDEAD_BEEF);
    sig_check("led_out", 32'(led), 32'hA5);
    sig_check("digi_out", 32'(digi), 32'hFFF);
    bus_read("unmapped_rd", 32'h4000_0200, 1'b1, 32'h0);
    bus_read("unaligned_rd", 32'h4000_0101, 1'b1, 32'h0);
    bus_read("rd_low", A_LED, 1'b0, 32'h0);
    bus_read("led_reg", A_LED, 1'b1, 32'hA5);
    bus_read("digi_reg", A_DIGI, 1'b1, 32'hFFF);
    bus.wr = 1'b1; bus.wdata = 32'h5A;
    bus_read("rd_wr_prewrite", A_LED, 1'b1, 32'hA5);
    bus.wr = 1'b0;
    sig_check("rd_wr_led", 32'(led), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
